// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_restoring_divider_pkg;

    localparam int unsigned DEF_DIVIDEND_W = 8;
    localparam int unsigned DEF_DIVISOR_W  = 4;
    localparam int unsigned DEF_CNT_W      = $clog2(DEF_DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // States in which a division is in flight and new requests are refused.
    function automatic logic is_busy_state(input div_state_e s);
        return (s == ST_RUN) || (s == ST_FIX);
    endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_restoring_divider_if
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) ();

    logic                  start;
    logic                  signed_mode;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  busy;
    logic                  done;
    logic [DIVIDEND_W-1:0] quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero, overflow
    );

endinterface

// File: rtl/seq_restoring_divider_twos_negate.sv
// Combinational conditional two's-complement negate: out = neg ? -in : in.
module seq_restoring_divider_twos_negate #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_in,
    input  logic         i_neg,
    output logic [W-1:0] o_out_c
);

    assign o_out_c = i_neg ? (~i_in + W'(1)) : i_in;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, then a sign-fix cycle.
module seq_restoring_divider
    import seq_restoring_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_restoring_divider_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);
    localparam int unsigned SUB_W = DIVISOR_W + 2;

    div_state_e            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_acc;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [DIVISOR_W-1:0]  r_dsr;
    logic [DIVISOR_W-1:0]  r_dvd_lo;
    logic                  r_signed;
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic                  r_busy;
    logic                  r_done;
    logic [DIVIDEND_W-1:0] r_quot;
    logic [DIVISOR_W-1:0]  r_remd;
    logic                  r_dbz;
    logic                  r_ovf;

    div_state_e            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [DIVIDEND_W-1:0] w_acc_nxt;
    logic [DIVISOR_W-1:0]  w_rem_nxt;
    logic [DIVISOR_W-1:0]  w_dsr_nxt;
    logic [DIVISOR_W-1:0]  w_dvd_lo_nxt;
    logic                  w_signed_nxt;
    logic                  w_q_neg_nxt;
    logic                  w_r_neg_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [DIVIDEND_W-1:0] w_quot_nxt;
    logic [DIVISOR_W-1:0]  w_remd_nxt;
    logic                  w_dbz_nxt;
    logic                  w_ovf_nxt;

    logic                  w_dvd_neg;
    logic                  w_dsr_neg;
    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dsr_mag;
    logic [DIVIDEND_W-1:0] w_q_fix;
    logic [DIVISOR_W-1:0]  w_r_fix;
    logic [DIVISOR_W:0]    w_rem_shift;
    logic [SUB_W-1:0]      w_diff;
    logic                  w_sub_ok;

    assign w_dvd_neg = bus.signed_mode & bus.dividend[DIVIDEND_W-1];
    assign w_dsr_neg = bus.signed_mode & bus.divisor[DIVISOR_W-1];

    seq_restoring_divider_twos_negate #(.W(DIVIDEND_W)) u_dvd_mag (
        .i_in    (bus.dividend),
        .i_neg   (w_dvd_neg),
        .o_out_c (w_dvd_mag)
    );

    seq_restoring_divider_twos_negate #(.W(DIVISOR_W)) u_dsr_mag (
        .i_in    (bus.divisor),
        .i_neg   (w_dsr_neg),
        .o_out_c (w_dsr_mag)
    );

    seq_restoring_divider_twos_negate #(.W(DIVIDEND_W)) u_q_fix (
        .i_in    (r_acc),
        .i_neg   (r_q_neg),
        .o_out_c (w_q_fix)
    );

    seq_restoring_divider_twos_negate #(.W(DIVISOR_W)) u_r_fix (
        .i_in    (r_rem),
        .i_neg   (r_r_neg),
        .o_out_c (w_r_fix)
    );

    // Shift-in of the next dividend bit and trial subtraction; sign bit of w_diff decides restore.
    assign w_rem_shift = {r_rem, r_acc[DIVIDEND_W-1]};
    assign w_diff      = SUB_W'(w_rem_shift) - SUB_W'(r_dsr);
    assign w_sub_ok    = ~w_diff[SUB_W-1];

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_acc_nxt    = r_acc;
        w_rem_nxt    = r_rem;
        w_dsr_nxt    = r_dsr;
        w_dvd_lo_nxt = r_dvd_lo;
        w_signed_nxt = r_signed;
        w_q_neg_nxt  = r_q_neg;
        w_r_neg_nxt  = r_r_neg;
        w_quot_nxt   = r_quot;
        w_remd_nxt   = r_remd;
        w_dbz_nxt    = r_dbz;
        w_ovf_nxt    = r_ovf;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_state_nxt = ST_IDLE;
                if (bus.start) begin
                    w_state_nxt  = ST_RUN;
                    w_cnt_nxt    = CNT_W'(DIVIDEND_W);
                    w_acc_nxt    = w_dvd_mag;
                    w_rem_nxt    = '0;
                    w_dsr_nxt    = w_dsr_mag;
                    w_dvd_lo_nxt = bus.dividend[DIVISOR_W-1:0];
                    w_signed_nxt = bus.signed_mode;
                    w_q_neg_nxt  = w_dvd_neg ^ w_dsr_neg;
                    w_r_neg_nxt  = w_dvd_neg;
                    w_dbz_nxt    = 1'b0;
                    w_ovf_nxt    = 1'b0;
                end
            end
            ST_RUN: begin
                w_acc_nxt = {r_acc[DIVIDEND_W-2:0], w_sub_ok};
                w_rem_nxt = w_sub_ok ? DIVISOR_W'(w_diff) : DIVISOR_W'(w_rem_shift);
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                w_state_nxt = ST_DONE;
                if (r_dsr == '0) begin
                    w_quot_nxt = {DIVIDEND_W{1'b1}};
                    w_remd_nxt = r_dvd_lo;
                    w_dbz_nxt  = 1'b1;
                    w_ovf_nxt  = 1'b0;
                end else begin
                    w_quot_nxt = w_q_fix;
                    w_remd_nxt = w_r_fix;
                    w_dbz_nxt  = 1'b0;
                    // A positive signed quotient with the top magnitude bit set cannot be represented.
                    w_ovf_nxt  = r_signed & ~r_q_neg & r_acc[DIVIDEND_W-1];
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = is_busy_state(w_state_nxt);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_dsr    <= '0;
            r_dvd_lo <= '0;
            r_signed <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_remd   <= '0;
            r_dbz    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_acc    <= w_acc_nxt;
            r_rem    <= w_rem_nxt;
            r_dsr    <= w_dsr_nxt;
            r_dvd_lo <= w_dvd_lo_nxt;
            r_signed <= w_signed_nxt;
            r_q_neg  <= w_q_neg_nxt;
            r_r_neg  <= w_r_neg_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_quot   <= w_quot_nxt;
            r_remd   <= w_remd_nxt;
            r_dbz    <= w_dbz_nxt;
            r_ovf    <= w_ovf_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remd;
    assign bus.div_by_zero = r_dbz;
    assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed cases plus randomized operands vs. an arithmetic model.
module tb_seq_restoring_divider;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    logic [7:0] last_q;
    logic [3:0] last_r;

    seq_restoring_divider_if bus_if ();

    seq_restoring_divider dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer division; SV int division truncates toward zero like the spec.
    task automatic ref_div(input logic sm, input logic [7:0] a, input logic [3:0] b,
                           output logic [7:0] q, output logic [3:0] r,
                           output logic dbz, output logic ovf);
        int sa;
        int sb;
        int qi;
        int ri;
        if (b == 4'd0) begin
            q   = 8'hFF;
            r   = a[3:0];
            dbz = 1'b1;
            ovf = 1'b0;
        end else begin
            if (sm) begin
                sa = int'($signed(a));
                sb = int'($signed(b));
            end else begin
                sa = int'(a);
                sb = int'(b);
            end
            qi  = sa / sb;
            ri  = sa % sb;
            q   = qi[7:0];
            r   = ri[3:0];
            dbz = 1'b0;
            ovf = sm && (qi > 127);
        end
    endtask

    // Present a request and consume the accepting edge; returns at accept edge + 1.
    task automatic start_op(input logic sm, input logic [7:0] a, input logic [3:0] b);
        bus_if.signed_mode = sm;
        bus_if.dividend    = a;
        bus_if.divisor     = b;
        bus_if.start       = 1'b1;
        @(posedge clk); #1;
        bus_if.start       = 1'b0;
        chk("accept_busy", 32'(bus_if.busy), 32'd1);
        chk("accept_no_done", 32'(bus_if.done), 32'd0);
        chk("accept_flags_clear", {30'd0, bus_if.div_by_zero, bus_if.overflow}, 32'd0);
        chk("accept_q_held", 32'(bus_if.quotient), 32'(last_q));
        bus_if.dividend    = 8'($urandom);
        bus_if.divisor     = 4'($urandom);
        bus_if.signed_mode = 1'($urandom);
    endtask

    // Wait for done (bounded), optionally pulsing an ignored start at edge inject_k after accept.
    task automatic finish_op(input string tag, input logic sm, input logic [7:0] a,
                             input logic [3:0] b, input int inject_k);
        logic [7:0] eq;
        logic [3:0] er;
        logic       edbz;
        logic       eovf;
        int         lat;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (k == inject_k) begin
                bus_if.start       = 1'b1;
                bus_if.dividend    = 8'($urandom);
                bus_if.divisor     = 4'($urandom);
                bus_if.signed_mode = ~sm;
            end
            @(posedge clk); #1;
            bus_if.start = 1'b0;
            if (bus_if.done) begin
                lat = k;
                break;
            end
            if (k < 9) chk({tag, "_busy_run"}, 32'(bus_if.busy), 32'd1);
        end
        // done seen 9 edges after the accepting edge, i.e. in cycle T+10 counting the start cycle
        chk({tag, "_latency"}, 32'(lat), 32'd9);
        ref_div(sm, a, b, eq, er, edbz, eovf);
        chk({tag, "_quotient"}, 32'(bus_if.quotient), 32'(eq));
        chk({tag, "_remainder"}, 32'(bus_if.remainder), 32'(er));
        chk({tag, "_div_by_zero"}, 32'(bus_if.div_by_zero), 32'(edbz));
        chk({tag, "_overflow"}, 32'(bus_if.overflow), 32'(eovf));
        chk({tag, "_busy_done"}, 32'(bus_if.busy), 32'd0);
        last_q = eq;
        last_r = er;
    endtask

    task automatic run_op(input string tag, input logic sm, input logic [7:0] a,
                          input logic [3:0] b, input int inject_k);
        start_op(sm, a, b);
        finish_op(tag, sm, a, b, inject_k);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus_if.done), 32'd0);
        chk("results_held", {20'd0, bus_if.quotient, bus_if.remainder}, {20'd0, last_q, last_r});
    endtask

    initial begin
        int done_seen;
        logic       sm;
        logic [7:0] a;
        logic [3:0] b;

        n_checks = 0;
        n_fail   = 0;
        last_q   = 8'h00;
        last_r   = 4'h0;
        rst_n              = 1'b0;
        bus_if.start       = 1'b0;
        bus_if.signed_mode = 1'b0;
        bus_if.dividend    = 8'h00;
        bus_if.divisor     = 4'h0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_results", {20'd0, bus_if.quotient, bus_if.remainder}, 32'd0);
        chk("rst_flags", {30'd0, bus_if.div_by_zero, bus_if.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-derived expectations alongside the model.
        run_op("u200_7", 1'b0, 8'hC8, 4'h7, 0);
        chk("u200_7_q_const", 32'(bus_if.quotient), 32'h1C);
        chk("u200_7_r_const", 32'(bus_if.remainder), 32'h4);
        idle_cycle();
        run_op("s_m100_7", 1'b1, 8'h9C, 4'h7, 0);
        chk("s_m100_7_q_const", 32'(bus_if.quotient), 32'hF2);
        chk("s_m100_7_r_const", 32'(bus_if.remainder), 32'hE);
        idle_cycle();
        run_op("s_100_m3", 1'b1, 8'h64, 4'hD, 0);
        chk("s_100_m3_q_const", 32'(bus_if.quotient), 32'hDF);
        chk("s_100_m3_r_const", 32'(bus_if.remainder), 32'h1);
        idle_cycle();
        run_op("div0", 1'b0, 8'h55, 4'h0, 0);
        chk("div0_const", {19'd0, bus_if.div_by_zero, bus_if.quotient, bus_if.remainder}, {19'd0, 1'b1, 8'hFF, 4'h5});
        idle_cycle();
        run_op("s_ovf", 1'b1, 8'h80, 4'hF, 0);
        chk("s_ovf_const", {19'd0, bus_if.overflow, bus_if.quotient, bus_if.remainder}, {19'd0, 1'b1, 8'h80, 4'h0});
        idle_cycle();
        run_op("u_ovf_ops", 1'b0, 8'h80, 4'hF, 0);
        chk("u_ovf_ops_const", {19'd0, bus_if.overflow, bus_if.quotient, bus_if.remainder}, {19'd0, 1'b0, 8'h08, 4'h8});
        idle_cycle();
        run_op("s_div0", 1'b1, 8'hF3, 4'h0, 0);
        idle_cycle();

        // Start while busy must be ignored; operands changed by the pulse have no effect.
        run_op("ignore_start", 1'b0, 8'hE7, 4'h9, 3);
        // Back-to-back: request in the done cycle is accepted on the next edge.
        run_op("b2b", 1'b1, 8'h81, 4'h3, 0);
        idle_cycle();

        // Reset in the middle of a division aborts it without a done pulse.
        start_op(1'b0, 8'hC8, 4'h7);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy", 32'(bus_if.busy), 32'd0);
        chk("mid_rst_outputs", {18'd0, bus_if.done, bus_if.div_by_zero, bus_if.overflow, bus_if.quotient, bus_if.remainder}, 32'd0);
        rst_n = 1'b1;
        last_q = 8'h00;
        last_r = 4'h0;
        done_seen = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            if (bus_if.done) done_seen++;
        end
        chk("mid_rst_no_done", 32'(done_seen), 32'd0);

        // Randomized operands, alternating chained and spaced requests.
        for (int i = 0; i < 48; i++) begin
            sm = 1'($urandom);
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            if (i % 8 == 5) begin
                sm = 1'b1;
                a  = 8'h80;
                b  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'h1;
            end
            run_op("rand", sm, a, b, (i % 5 == 2) ? 4 : 0);
            if (i % 3 == 0) idle_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
